// File: rtl/step_sequencer.sv
// step_sequencer
//   Generates step/direction pulses for a stepper motor driver. One
//   down-counter times every phase; the step period is clamped to a
//   minimum and latched at the start of each step, so the driver never
//   sees a step shorter than MIN_PERIOD.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | not stepping, waiting for go
//   DIR_SET | drv_dir just changed, holding dir-to-step setup time
//   HIGH    | drv_step = 1 for PULSE_HIGH cycles
//   LOW     | drv_step = 0 for eff_period - PULSE_HIGH cycles
//
// Ports
//   clk        system clock (50 MHz)
//   rst        synchronous active-high reset
//   drv_en_SM  stepping enable from the tracking controller
//   dir_req    requested direction, 1 = positive
//   period     rising-edge-to-rising-edge step period in clk cycles, 0 = stop
//   pos_clr    synchronous clear of position
//   drv_step   registered step pulse to the motor driver
//   drv_dir    registered direction to the motor driver
//   busy       high whenever the FSM is not IDLE
//   step_done  one-cycle strobe on the last cycle of each high phase
//   position   signed step count, wraps two's complement
module step_sequencer #(
  parameter int WIDTH_WORK = 16,
  parameter int WIDTH_POS  = 32,
  parameter int PULSE_HIGH = 100,
  parameter int DIR_SETUP  = 50,
  parameter int MIN_PERIOD = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drv_en_SM,
  input  logic                  dir_req,
  input  logic [WIDTH_WORK-1:0] period,
  input  logic                  pos_clr,
  output logic                  drv_step,
  output logic                  drv_dir,
  output logic                  busy,
  output logic                  step_done,
  output logic [WIDTH_POS-1:0]  position
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIR_SET = 2'd1,
    HIGH    = 2'd2,
    LOW     = 2'd3
  } state_t;

  localparam logic [WIDTH_WORK-1:0] PULSE_LAST = WIDTH_WORK'(PULSE_HIGH - 1);
  localparam logic [WIDTH_WORK-1:0] SETUP_LAST = WIDTH_WORK'(DIR_SETUP - 1);
  localparam logic [WIDTH_WORK-1:0] MIN_P      = WIDTH_WORK'(MIN_PERIOD);
  // LOW counter load: (eff_period - PULSE_HIGH) cycles, counted down to 0
  localparam logic [WIDTH_WORK-1:0] LOW_ADJ    = WIDTH_WORK'(PULSE_HIGH + 1);
  localparam logic [WIDTH_POS-1:0]  POS_ONE    = WIDTH_POS'(1);

  state_t                state_q, state_d;
  logic [WIDTH_WORK-1:0] cnt_q, cnt_d;
  logic [WIDTH_WORK-1:0] eff_q, eff_d;
  logic                  dir_q, dir_d;
  logic                  step_q, step_d;
  logic [WIDTH_POS-1:0]  pos_q, pos_d;
  logic                  go;
  logic                  done;
  logic [WIDTH_WORK-1:0] eff_clamped;

  always_comb begin
    go          = drv_en_SM && (period != '0);
    eff_clamped = (period < MIN_P) ? MIN_P : period;
    state_d     = state_q;
    cnt_d       = cnt_q;
    eff_d       = eff_q;
    dir_d       = dir_q;
    pos_d       = pos_q;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          if (dir_req == dir_q) begin
            state_d = HIGH;
            cnt_d   = PULSE_LAST;
            eff_d   = eff_clamped;
          end else begin
            state_d = DIR_SET;
            dir_d   = dir_req;
            cnt_d   = SETUP_LAST;
          end
        end
      end
      DIR_SET: begin
        if (!go) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = PULSE_LAST;
          eff_d   = eff_clamped;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          pos_d   = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
          state_d = LOW;
          cnt_d   = eff_q - LOW_ADJ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          if (go && (dir_req == dir_q)) begin
            state_d = HIGH;
            cnt_d   = PULSE_LAST;
            eff_d   = eff_clamped;
          end else if (go) begin
            state_d = DIR_SET;
            dir_d   = dir_req;
            cnt_d   = SETUP_LAST;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // clear takes priority over a simultaneous step update
    if (pos_clr) pos_d = '0;

    step_d = (state_d == HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      eff_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eff_q   <= eff_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      pos_q   <= pos_d;
    end
  end

  assign drv_step  = step_q;
  assign drv_dir   = dir_q;
  assign busy      = (state_q != IDLE);
  assign step_done = done;
  assign position  = pos_q;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        rst, drv_en_SM, dir_req, pos_clr, pos_clr_n;
  logic [15:0] period;
  logic        drv_step, drv_dir, busy, step_done;
  logic [31:0] position;
  logic        drv_step_n, drv_dir_n, busy_n, step_done_n;
  logic [3:0]  position_n;

  step_sequencer dut (
    .clk(clk), .rst(rst), .drv_en_SM(drv_en_SM), .dir_req(dir_req),
    .period(period), .pos_clr(pos_clr), .drv_step(drv_step),
    .drv_dir(drv_dir), .busy(busy), .step_done(step_done), .position(position)
  );

  // narrow-position copy used to observe signed wrap in a few steps
  step_sequencer #(.WIDTH_POS(4)) dut_w4 (
    .clk(clk), .rst(rst), .drv_en_SM(drv_en_SM), .dir_req(dir_req),
    .period(period), .pos_clr(pos_clr_n), .drv_step(drv_step_n),
    .drv_dir(drv_dir_n), .busy(busy_n), .step_done(step_done_n),
    .position(position_n)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          gap;   // 0 = first step after idle, gap not checked
    int          high;
    logic [31:0] pos;
  } step_exp_t;

  step_exp_t   exp_q[$];
  step_exp_t   e;
  logic [31:0] pos_model = '0;

  bit   mon_en = 1'b0;
  logic step_prev = 1'b0;
  logic sd_prev = 1'b0;
  int   last_rise = -1, rise_cyc = 0, rise_gap = 0;
  int   n_falls = 0, n_done = 0, done_in_pulse = 0;

  // scoreboard monitor: each completed pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (!mon_en) begin
      last_rise     = -1;
      done_in_pulse = 0;
    end else begin
      if (drv_step && !step_prev) begin
        rise_cyc      = cyc;
        rise_gap      = (last_rise < 0) ? 0 : cyc - last_rise;
        last_rise     = cyc;
        done_in_pulse = 0;
      end
      if (step_done) begin
        n_done++;
        done_in_pulse++;
      end
      if (!drv_step && step_prev) begin
        n_falls++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_step: pulse at cycle %0d, none expected", rise_cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc - rise_cyc !== e.high) begin
            n_err++;
            $display("FAIL high_time: got %0d want %0d", cyc - rise_cyc, e.high);
          end
          if (e.gap != 0) begin
            n_cmp++;
            if (rise_gap !== e.gap) begin
              n_err++;
              $display("FAIL step_gap: got %0d want %0d", rise_gap, e.gap);
            end
          end
          n_cmp++;
          if (position !== e.pos) begin
            n_err++;
            $display("FAIL step_pos: got %h want %h", position, e.pos);
          end
          n_cmp++;
          if (done_in_pulse !== 1 || sd_prev !== 1'b1) begin
            n_err++;
            $display("FAIL step_done_strobe: count %0d last_cycle %b want 1 1",
                     done_in_pulse, sd_prev);
          end
        end
      end
    end
    sd_prev   = step_done;
    step_prev = drv_step;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_step(input int gap, input bit up);
    pos_model = up ? pos_model + 32'd1 : pos_model - 32'd1;
    exp_q.push_back('{gap, 100, pos_model});
  endtask

  task automatic wait_falls(input int target, input int budget, input string tag);
    int k = 0;
    while (n_falls < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_falls < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, falls %0d want %0d", tag, n_falls, target);
    end
  endtask

  task automatic wait_step(input logic v, input int budget, input string tag);
    int k = 0;
    while (drv_step !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (drv_step !== v) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, drv_step %b want %b", tag, drv_step, v);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, busy %b want 0", tag, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; drv_en_SM = 1'b0; dir_req = 1'b0; period = '0;
    pos_clr = 1'b0; pos_clr_n = 1'b0;
    tick(3);
    n_cmp++;
    if ({drv_step, drv_dir, busy, step_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: step/dir/busy/done %b want 0000",
               {drv_step, drv_dir, busy, step_done});
    end
    n_cmp++;
    if (position !== 32'd0) begin
      n_err++;
      $display("FAIL reset_position: got %h want 0", position);
    end
    rst = 1'b0;
    tick(2);
    pos_model = '0;
    mon_en    = 1'b1;
  endtask

  task automatic test_steady;
    int base = n_falls;
    int d0   = n_done;
    dir_req = 1'b0; period = 16'd1000; drv_en_SM = 1'b1;
    push_step(0, 1'b0);
    for (int i = 0; i < 4; i++) push_step(1000, 1'b0);
    tick(1);
    n_cmp++;
    if (drv_step !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL steady_start: step %b busy %b want 1 1", drv_step, busy);
    end
    wait_falls(base + 5, 6000, "steady_falls");
    drv_en_SM = 1'b0;
    wait_idle(2000, "steady_idle");
    n_cmp++;
    if (position !== 32'hFFFF_FFFB) begin
      n_err++;
      $display("FAIL steady_position: got %h want fffffffb", position);
    end
    n_cmp++;
    if (n_done - d0 !== 5) begin
      n_err++;
      $display("FAIL steady_done_count: got %0d want 5", n_done - d0);
    end
  endtask

  task automatic test_dir_change;
    int base = n_falls;
    int t_dir;
    int k = 0;
    dir_req = 1'b0; period = 16'd1000; drv_en_SM = 1'b1;
    push_step(0, 1'b0);
    wait_falls(base + 1, 1500, "dir_first_fall");
    dir_req = 1'b1;
    push_step(1050, 1'b1);
    push_step(1000, 1'b1);
    while (drv_dir !== 1'b1 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    t_dir = cyc;
    n_cmp++;
    if (drv_dir !== 1'b1 || drv_step !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL dir_switch: dir %b step %b busy %b want 1 0 1",
               drv_dir, drv_step, busy);
    end
    wait_step(1'b1, 200, "dir_setup_rise");
    n_cmp++;
    if (cyc - t_dir !== 50) begin
      n_err++;
      $display("FAIL dir_setup_time: got %0d want 50", cyc - t_dir);
    end
    wait_falls(base + 3, 3000, "dir_falls");
    drv_en_SM = 1'b0;
    wait_idle(2000, "dir_idle");
    n_cmp++;
    if (position !== pos_model || drv_dir !== 1'b1) begin
      n_err++;
      $display("FAIL dir_final: pos %h dir %b want %h 1", position, drv_dir, pos_model);
    end
  endtask

  task automatic test_clamp;
    int base = n_falls;
    int t_fall;
    dir_req = 1'b1; period = 16'd50; drv_en_SM = 1'b1;
    push_step(0, 1'b1);
    push_step(200, 1'b1);
    push_step(200, 1'b1);
    wait_falls(base + 2, 1000, "clamp_falls");
    wait_step(1'b1, 300, "clamp_third_rise");
    wait_step(1'b0, 300, "clamp_third_fall");
    period = '0;
    t_fall = cyc;
    wait_idle(500, "clamp_idle");
    n_cmp++;
    if (cyc - t_fall !== 100) begin
      n_err++;
      $display("FAIL clamp_low_time: got %0d want 100", cyc - t_fall);
    end
    tick(5);
    n_cmp++;
    if (busy !== 1'b0 || drv_step !== 1'b0) begin
      n_err++;
      $display("FAIL clamp_stop: busy %b step %b want 0 0", busy, drv_step);
    end
    drv_en_SM = 1'b0;
  endtask

  task automatic test_enable_drop;
    int t_fall;
    logic [31:0] pos0 = position;
    dir_req = 1'b1; period = 16'd1000; drv_en_SM = 1'b1;
    push_step(0, 1'b1);
    wait_step(1'b1, 100, "drop_rise");
    tick(10);
    drv_en_SM = 1'b0;
    period    = 16'd300;
    wait_step(1'b0, 200, "drop_fall");
    t_fall = cyc;
    wait_idle(1500, "drop_idle");
    n_cmp++;
    if (cyc - t_fall !== 900) begin
      n_err++;
      $display("FAIL drop_low_time: got %0d want 900", cyc - t_fall);
    end
    tick(20);
    n_cmp++;
    if (position !== pos0 + 32'd1 || busy !== 1'b0 || drv_step !== 1'b0) begin
      n_err++;
      $display("FAIL drop_final: pos %h busy %b step %b want %h 0 0",
               position, busy, drv_step, pos0 + 32'd1);
    end
  endtask

  task automatic test_pos_clr_wrap;
    int strobes = 0;
    int k = 0;
    pos_clr = 1'b1; pos_clr_n = 1'b1;
    tick(1);
    pos_clr = 1'b0; pos_clr_n = 1'b0;
    pos_model = '0;
    n_cmp++;
    if (position !== 32'd0 || position_n !== 4'd0) begin
      n_err++;
      $display("FAIL clr_idle: pos %h narrow %h want 0 0", position, position_n);
    end
    dir_req = 1'b1; period = 16'd200; drv_en_SM = 1'b1;
    push_step(0, 1'b1);
    for (int i = 0; i < 6; i++) push_step(200, 1'b1);
    exp_q.push_back('{200, 100, 32'd0});
    while (strobes < 8 && k < 4000) begin
      @(negedge clk);
      k++;
      if (step_done) strobes++;
    end
    n_cmp++;
    if (strobes !== 8 || position !== 32'd7 || position_n !== 4'h7) begin
      n_err++;
      $display("FAIL clr_pre: strobes %0d pos %h narrow %h want 8 7 7",
               strobes, position, position_n);
    end
    pos_clr   = 1'b1;
    drv_en_SM = 1'b0;
    pos_model = '0;
    tick(1);
    pos_clr = 1'b0;
    n_cmp++;
    if (position !== 32'd0) begin
      n_err++;
      $display("FAIL clr_wins: got %h want 0", position);
    end
    n_cmp++;
    if (position_n !== 4'h8) begin
      n_err++;
      $display("FAIL wrap_pos_max: got %h want 8", position_n);
    end
    wait_idle(500, "clr_idle");
  endtask

  task automatic test_reset_mid_pulse;
    dir_req = 1'b1; period = 16'd200; drv_en_SM = 1'b1;
    push_step(0, 1'b1);
    wait_falls(n_falls + 1, 300, "rst_first_fall");
    mon_en = 1'b0;
    wait_step(1'b1, 300, "rst_second_rise");
    tick(10);
    n_cmp++;
    if (position !== 32'd1 || drv_dir !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: pos %h dir %b busy %b want 1 1 1", position, drv_dir, busy);
    end
    rst = 1'b1;
    tick(1);
    n_cmp++;
    if ({drv_step, drv_dir, busy, step_done} !== 4'b0000 || position !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_pulse: step/dir/busy/done %b pos %h want 0000 0",
               {drv_step, drv_dir, busy, step_done}, position);
    end
    rst = 1'b0; drv_en_SM = 1'b0; period = '0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_dir_change();
    test_clamp();
    test_enable_drop();
    test_pos_clr_wrap();
    test_reset_mid_pulse();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL leftover_steps: %0d expected pulses never seen", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
